// File: rtl/hazard_forward_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_if
// Bundle between the execute stage / data memory / register file and the
// hazard_forward_unit. The unit owns the "master" modport (it produces the
// forwarding selects, forwarded operands, stall/flush and memory/WB outputs);
// the surrounding pipeline uses "slave".
//   Pipeline -> unit : ex_* controls and data, ex_rs/ex_rt, id_rs/id_rt,
//                      mem_readData (combinational from mem_aluResult)
//   Unit -> pipeline : ForwardAE/BE, reg_muxes_b/d, stallF/stallD/flushE,
//                      mem_aluResult/mem_writeData/mem_memWrite,
//                      wb_regWrite/wb_writeReg/wb_writeData
// Optional macro HAZARD_STATS_EN adds stall_count and fwd_count (32-bit).
// ---------------------------------------------------------------------------
interface hazard_forward_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              ex_regWrite;
    logic              ex_memToReg;
    logic              ex_memRead;
    logic              ex_memWrite;
    logic [DATA_W-1:0] ex_aluResult;
    logic [DATA_W-1:0] ex_reg2Out;
    logic [REG_W-1:0]  ex_writeReg;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [DATA_W-1:0] mem_readData;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [DATA_W-1:0] reg_muxes_b;
    logic [DATA_W-1:0] reg_muxes_d;
    logic              stallF;
    logic              stallD;
    logic              flushE;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memWrite;
    logic              wb_regWrite;
    logic [REG_W-1:0]  wb_writeReg;
    logic [DATA_W-1:0] wb_writeData;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_count;
    logic [31:0]       fwd_count;
`endif

    modport master (
        input  ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
        input  ex_aluResult, ex_reg2Out, ex_writeReg, ex_rs, ex_rt,
        input  id_rs, id_rt, mem_readData,
        output ForwardAE, ForwardBE, reg_muxes_b, reg_muxes_d,
        output stallF, stallD, flushE,
        output mem_aluResult, mem_writeData, mem_memWrite,
        output wb_regWrite, wb_writeReg, wb_writeData
`ifdef HAZARD_STATS_EN
        , output stall_count, fwd_count
`endif
    );

    modport slave (
        output ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
        output ex_aluResult, ex_reg2Out, ex_writeReg, ex_rs, ex_rt,
        output id_rs, id_rt, mem_readData,
        input  ForwardAE, ForwardBE, reg_muxes_b, reg_muxes_d,
        input  stallF, stallD, flushE,
        input  mem_aluResult, mem_writeData, mem_memWrite,
        input  wb_regWrite, wb_writeReg, wb_writeData
`ifdef HAZARD_STATS_EN
        , input stall_count, fwd_count
`endif
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
// Holds the EX/MEM and MEM/WB pipeline registers, generates the execute-stage
// operand forwarding selects and detects load-use hazards.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears both pipeline registers
//   bus   - hazard_forward_unit_if.master (see interface file for signals)
// Optional macro HAZARD_STATS_EN: adds wrapping 32-bit stall_count (cycles
// with stallD) and fwd_count (cycles with any non-zero forward select).
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_forward_unit_if.master  bus
);
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] reg2_out;
        logic [REG_W-1:0]  write_reg;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
    } mem_wb_t;

    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic [1:0] fwd_a, fwd_b;
    logic       load_use;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = bus.ex_regWrite;
        ex_mem_d.mem_to_reg = bus.ex_memToReg;
        ex_mem_d.mem_write  = bus.ex_memWrite;
        ex_mem_d.alu_result = bus.ex_aluResult;
        ex_mem_d.reg2_out   = bus.ex_reg2Out;
        ex_mem_d.write_reg  = bus.ex_writeReg;

        mem_wb_d            = '0;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.write_reg  = ex_mem_q.write_reg;
        mem_wb_d.alu_result = ex_mem_q.alu_result;
        mem_wb_d.read_data  = bus.mem_readData;
    end

    // Forwarding: the younger result (EX/MEM) wins over MEM/WB; $0 is never
    // forwarded. Selects are held at 00 during reset.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_mem_q.reg_write && ex_mem_q.write_reg != '0 &&
            ex_mem_q.write_reg == bus.ex_rs)
            fwd_a = 2'b01;
        else if (mem_wb_q.reg_write && mem_wb_q.write_reg != '0 &&
                 mem_wb_q.write_reg == bus.ex_rs)
            fwd_a = 2'b10;
        if (ex_mem_q.reg_write && ex_mem_q.write_reg != '0 &&
            ex_mem_q.write_reg == bus.ex_rt)
            fwd_b = 2'b01;
        else if (mem_wb_q.reg_write && mem_wb_q.write_reg != '0 &&
                 mem_wb_q.write_reg == bus.ex_rt)
            fwd_b = 2'b10;
        if (reset) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // A load in EX whose destination is read by the instruction in ID cannot
    // be forwarded in time: hold IF/ID for one cycle and bubble ID/EX.
    always_comb begin
        load_use = bus.ex_memRead && bus.ex_writeReg != '0 &&
                   (bus.ex_writeReg == bus.id_rs || bus.ex_writeReg == bus.id_rt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.ForwardAE     = fwd_a;
    assign bus.ForwardBE     = fwd_b;
    assign bus.stallF        = load_use && !reset;
    assign bus.stallD        = load_use && !reset;
    // Reset fills ID/EX with a bubble so nothing stale issues after release.
    assign bus.flushE        = load_use || reset;
    assign bus.reg_muxes_b   = ex_mem_q.alu_result;
    assign bus.mem_aluResult = ex_mem_q.alu_result;
    assign bus.mem_writeData = ex_mem_q.reg2_out;
    assign bus.mem_memWrite  = ex_mem_q.mem_write;
    assign bus.reg_muxes_d   = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;
    assign bus.wb_writeData  = bus.reg_muxes_d;
    assign bus.wb_regWrite   = mem_wb_q.reg_write;
    assign bus.wb_writeReg   = mem_wb_q.write_reg;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_d, stall_count_q;
    logic [31:0] fwd_count_d, fwd_count_q;

    always_comb begin
        stall_count_d = stall_count_q + ((load_use && !reset) ? 32'd1 : 32'd0);
        fwd_count_d   = fwd_count_q + ((fwd_a != 2'b00 || fwd_b != 2'b00) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.fwd_count   = fwd_count_q;
`endif
endmodule
